// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module  : alu_ctrl_pkg
// Brief   : Shared widths, FSM state encoding and ALU opcodes for the ALU arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;
   localparam int DATA_W = 32;
   localparam int OP_W   = 5;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [OP_W-1:0] ALU_ADD = 5'h01;
   localparam logic [OP_W-1:0] ALU_SUB = 5'h02;
   localparam logic [OP_W-1:0] ALU_AND = 5'h03;
   localparam logic [OP_W-1:0] ALU_OR  = 5'h04;
   localparam logic [OP_W-1:0] ALU_XOR = 5'h05;
endpackage

`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
// ============================================================================
// Module  : alu_share_arbiter_if
// Brief   : Request/response channels of both requesters plus the ALU hookup.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_share_arbiter_if #(
   parameter int DW = alu_ctrl_pkg::DATA_W,
   parameter int OW = alu_ctrl_pkg::OP_W
);
   logic          req0_valid;
   logic          req0_ready;
   logic [DW-1:0] req0_a;
   logic [DW-1:0] req0_b;
   logic [OW-1:0] req0_op;
   logic          req1_valid;
   logic          req1_ready;
   logic [DW-1:0] req1_a;
   logic [DW-1:0] req1_b;
   logic [OW-1:0] req1_op;
   logic          rsp0_valid;
   logic          rsp0_ready;
   logic          rsp1_valid;
   logic          rsp1_ready;
   logic [DW-1:0] rsp_data;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [OW-1:0] alu_op;
   logic [DW-1:0] alu_out;
   logic          busy;

   // Arbiter side
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp0_ready, rsp1_ready, alu_out,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
      output alu_a, alu_b, alu_op, busy
   );

   // Issue logic / ALU side
   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp0_ready, rsp1_ready, alu_out,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
      input  alu_a, alu_b, alu_op, busy
   );
endinterface

`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way combinational round-robin arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  wire logic [1:0] req,
   input  wire logic       last_grant,
   output logic            grant_valid,
   output logic            grant_id
);
   // On a tie the requester not served last wins; a lone requester always wins.
   assign grant_valid = |req;
   assign grant_id    = (&req) ? ~last_grant : req[1];
endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module  : alu_share_arbiter
// Brief   : Round-robin sharing of one combinational ALU between two requesters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
   parameter int DATA_W = alu_ctrl_pkg::DATA_W,
   parameter int OP_W   = alu_ctrl_pkg::OP_W
) (
   input  wire logic          clk,
   input  wire logic          rst,
   alu_share_arbiter_if.slave bus
);
   import alu_ctrl_pkg::*;

   logic [1:0]        r_state;
   logic              r_last_grant;
   logic              r_gid;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [OP_W-1:0]   r_alu_op;
   logic [DATA_W-1:0] r_result;

   logic              w_grant_valid;
   logic              w_grant_id;
   logic              w_accept;
   logic              w_rsp_done;
   logic [DATA_W-1:0] w_sel_a;
   logic [DATA_W-1:0] w_sel_b;
   logic [OP_W-1:0]   w_sel_op;

   rr_arb2 u_arb (
      .req         ({bus.req1_valid, bus.req0_valid}),
      .last_grant  (r_last_grant),
      .grant_valid (w_grant_valid),
      .grant_id    (w_grant_id)
   );

   assign w_accept   = (r_state == IDLE) && w_grant_valid;
   assign w_rsp_done = (r_state == RESP) && (r_gid ? bus.rsp1_ready : bus.rsp0_ready);
   assign w_sel_a    = w_grant_id ? bus.req1_a  : bus.req0_a;
   assign w_sel_b    = w_grant_id ? bus.req1_b  : bus.req0_b;
   assign w_sel_op   = w_grant_id ? bus.req1_op : bus.req0_op;

   assign bus.req0_ready = w_accept && !w_grant_id;
   assign bus.req1_ready = w_accept &&  w_grant_id;
   assign bus.rsp0_valid = (r_state == RESP) && !r_gid;
   assign bus.rsp1_valid = (r_state == RESP) &&  r_gid;
   assign bus.rsp_data   = r_result;
   assign bus.alu_a      = r_alu_a;
   assign bus.alu_b      = r_alu_b;
   assign bus.alu_op     = r_alu_op;
   assign bus.busy       = (r_state != IDLE);

   // Operand and result registers are never cleared outside reset; they hold
   // the last transaction for observability.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
         r_gid        <= 1'b0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= '0;
         r_result     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_alu_a  <= w_sel_a;
                  r_alu_b  <= w_sel_b;
                  r_alu_op <= w_sel_op;
                  r_gid    <= w_grant_id;
                  r_state  <= EXEC;
               end
            end
            EXEC: begin
               r_result <= bus.alu_out;
               r_state  <= RESP;
            end
            RESP: begin
               if (w_rsp_done) begin
                  r_last_grant <= r_gid;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire
